dual_pt_sram_param: RTL and testbench

//   Parametrised simple dual-port SRAM: one write port, one read port, single clock.

---
 rtl/dual_pt_sram_param.sv | 144 ++++++++++++++
 tb/tb_dual_pt_sram_param.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dual_pt_sram_param.sv
// Parametrised simple dual-port SRAM: one write port, one read port, single clock.
// Registered read with a one-cycle valid strobe, selectable read-during-write
// behaviour, and a hardware sweep that fills every word with INIT_VAL after reset.
// Optional feature macro: PARITY_EN adds an even-parity bit per word, an error
// injection input and a registered parity_err flag. Without it perr_inj is
// ignored and parity_err is tied low.
module dual_pt_sram_param #(
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       ADDR_W   = 4,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  parameter int unsigned       RDW_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen,
  input  logic [ADDR_W-1:0] addrw,
  input  logic [DATA_W-1:0] din,
  input  logic              ren,
  input  logic [ADDR_W-1:0] addrr,
  input  logic              perr_inj,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              init_busy,
  output logic              parity_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif

  localparam logic [0:0] StInit = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [MEM_W-1:0]  r_mem [DEPTH];
  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_vld;

  logic              w_init;
  logic              w_we;
  logic [ADDR_W-1:0] w_wa;
  logic [MEM_W-1:0]  w_wd;
  logic [MEM_W-1:0]  w_user_word;
  logic [MEM_W-1:0]  w_init_word;
  logic [MEM_W-1:0]  w_rd_word;

  assign w_init = (r_state == StInit);

`ifdef PARITY_EN
  // Stored bit keeps the word even-parity; perr_inj deliberately corrupts it.
  assign w_user_word = {(^din) ^ perr_inj, din};
  assign w_init_word = {^INIT_VAL, INIT_VAL};
`else
  logic w_unused_perr_inj;
  assign w_unused_perr_inj = perr_inj;
  assign w_user_word = din;
  assign w_init_word = INIT_VAL;
`endif

  // Write-port mux: the init sweep owns the write port until the FSM reaches RUN.
  always_comb begin
    w_we = 1'b0;
    w_wa = addrw;
    w_wd = w_user_word;
    if (!rst) begin
      if (w_init) begin
        w_we = 1'b1;
        w_wa = r_cnt;
        w_wd = w_init_word;
      end else begin
        w_we = wen;
      end
    end
  end

  // Read word selection, with optional forwarding of the concurrent write.
  always_comb begin
    w_rd_word = r_mem[addrr];
    if ((RDW_MODE == 1) && wen && (addrw == addrr)) begin
      w_rd_word = w_user_word;
    end
  end

  // Memory array; contents are not reset, the sweep initialises them.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_wa] <= w_wd;
    end
  end

  // Init/run FSM and sweep counter; the last sweep write moves the FSM to RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StInit;
      r_cnt   <= '0;
    end else if (w_init) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == {ADDR_W{1'b1}}) begin
        r_state <= StRun;
      end
    end
  end

  // Registered read port; dout holds when no read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
    end else if (!w_init && ren) begin
      r_dout     <= w_rd_word[DATA_W-1:0];
      r_dout_vld <= 1'b1;
    end else begin
      r_dout_vld <= 1'b0;
    end
  end

`ifdef PARITY_EN
  logic r_parity_err;

  // Parity check registered alongside dout; only meaningful while dout_vld is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_parity_err <= 1'b0;
    end else if (!w_init && ren) begin
      r_parity_err <= ^w_rd_word;
    end else begin
      r_parity_err <= 1'b0;
    end
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  assign dout      = r_dout;
  assign dout_vld  = r_dout_vld;
  assign init_busy = w_init;

endmodule

// File: tb/tb_dual_pt_sram_param.sv
// Scoreboard bench for dual_pt_sram_param: reads push expected words into a
// queue, a monitor pops and compares whenever dout_vld is seen.
module tb_dual_pt_sram_param;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 4;
  localparam logic [7:0]  INIT_VAL = 8'h3C;
  localparam int unsigned RDW_MODE = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       p;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              wen;
  logic [ADDR_W-1:0] addrw;
  logic [DATA_W-1:0] din;
  logic              ren;
  logic [ADDR_W-1:0] addrr;
  logic              perr_inj;
  logic [DATA_W-1:0] dout;
  logic              dout_vld;
  logic              init_busy;
  logic              parity_err;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  dual_pt_sram_param #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .INIT_VAL(INIT_VAL),
    .RDW_MODE(RDW_MODE)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .wen       (wen),
    .addrw     (addrw),
    .din       (din),
    .ren       (ren),
    .addrr     (addrr),
    .perr_inj  (perr_inj),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .init_busy (init_busy),
    .parity_err(parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue a read now; the expected result is queued for the monitor.
  task automatic rd(input logic [3:0] a, input logic [7:0] d, input logic p);
    exp_t e;
    ren   = 1'b1;
    addrr = a;
    e.d   = d;
    e.p   = p;
    exp_q.push_back(e);
    cyc();
    ren = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic inj);
    wen      = 1'b1;
    addrw    = a;
    din      = d;
    perr_inj = inj;
    cyc();
    wen      = 1'b0;
    perr_inj = 1'b0;
  endtask

  // Expects the sweep to start on the next edge and last exactly 16 edges.
  task automatic check_sweep();
    for (int i = 0; i < 16; i++) begin
      chk("init_busy_high", init_busy, 1);
      chk("vld_during_init", dout_vld, 0);
      cyc();
    end
    chk("init_busy_done", init_busy, 0);
  endtask

  // Monitor: compare every valid output against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (dout_vld) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_vld", 32'(dout_vld), 0);
        end else begin
          e = exp_q.pop_front();
          chk("dout", 32'(dout), 32'(e.d));
          chk("parity_err", 32'(parity_err), 32'(e.p));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic perr_exp;
`ifdef PARITY_EN
    perr_exp = 1'b1;
`else
    perr_exp = 1'b0;
`endif
    rst = 1'b1; wen = 1'b1; ren = 1'b1; addrw = 4'd5; din = 8'hEE; addrr = 4'd0;
    perr_inj = 1'b0;
    cyc();
    chk("rst_dout", dout, 0);
    chk("rst_vld", dout_vld, 0);
    chk("rst_perr", parity_err, 0);

    // 1: sweep ignores ports, then every word reads INIT_VAL.
    rst = 1'b0;
    check_sweep();
    wen = 1'b0; ren = 1'b0;
    for (int i = 0; i < 16; i++) rd(4'(i), 8'h3C, 1'b0);
    cyc();
    chk("vld_low_after_reads", dout_vld, 0);

    // 2: writes then back-to-back reads.
    wr(4'd12, 8'd246, 1'b0);
    wr(4'd11, 8'd200, 1'b0);
    wr(4'd10, 8'd144, 1'b0);
    ren = 1'b1; addrr = 4'd12; exp_q.push_back({8'd246, 1'b0}); cyc();
    addrr = 4'd11; exp_q.push_back({8'd200, 1'b0}); cyc();
    chk("b2b_vld_1", dout_vld, 1);
    addrr = 4'd10; exp_q.push_back({8'd144, 1'b0}); cyc();
    chk("b2b_vld_2", dout_vld, 1);
    ren = 1'b0;
    cyc();
    chk("b2b_vld_end", dout_vld, 0);

    // 3: same-address read-during-write.
    wen = 1'b1; addrw = 4'd10; din = 8'd55;
    rd(4'd10, (RDW_MODE == 1) ? 8'd55 : 8'd144, 1'b0);
    wen = 1'b0;
    rd(4'd10, 8'd55, 1'b0);
    cyc();

    // 4: dout holds while writes hit the address and no read is issued.
    rd(4'd11, 8'd200, 1'b0);
    for (int i = 0; i < 3; i++) begin
      wr(4'd11, 8'(77 + i), 1'b0);
      chk("hold_dout", dout, 200);
      chk("hold_vld", dout_vld, 0);
    end
    rd(4'd11, 8'd79, 1'b0);
    cyc();

    // 6: parity injection and repair.
    wr(4'd3, 8'hA5, 1'b1);
    rd(4'd3, 8'hA5, perr_exp);
    wr(4'd3, 8'hA5, 1'b0);
    rd(4'd3, 8'hA5, 1'b0);
    cyc();

    // 5: reset mid-sweep restarts the full sweep.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) cyc();
    chk("mid_sweep_busy", init_busy, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0; wen = 1'b1; ren = 1'b1; addrw = 4'd7; din = 8'h11;
    check_sweep();
    wen = 1'b0; ren = 1'b0;
    rd(4'd10, 8'h3C, 1'b0);
    rd(4'd3, 8'h3C, 1'b0);
    rd(4'd7, 8'h3C, 1'b0);
    cyc();
    cyc();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
